lt24_touch_response: RTL and testbench
======================================

// Module: lt24_touch_response
// PURPOSE
//  SPI master for the LT24 touch controller (ADS7843-compatible) on DE0-nano.
//  On a start pulse it shifts out an 8-bit command, reads back a 12-bit
//  conversion and publishes the upper 8 bits as a stable response byte.
//  It sits directly upstream of the 8-bit response input PIO: response[7:0]
//  drives that PIO's in_port, which software reads over Avalon at offset 0.
// PARAMETERS
//  CLK_DIV     16  clk cycles per SCLK half-period (min 2; 50MHz/32 = 1.5625MHz SCLK)
//  SYNC_STAGES 2   synchroniser depth for spi_miso and pen_irq_n (min 2)
// PORTS
//  clk        in   1   system clock (50 MHz)
//  reset_n    in   1   asynchronous reset, active-low
//  start      in   1   one-cycle request; honoured only in IDLE
//  cmd        in   8   command byte; captured on the cycle start is honoured
//  spi_miso   in   1   touch controller DOUT
//  pen_irq_n  in   1   touch controller PENIRQ, active-low, asynchronous
//  spi_sclk   out  1   SPI clock; idles low
//  spi_cs_n   out  1   chip select, active-low
//  spi_mosi   out  1   touch controller DIN, MSB first
//  busy       out  1   high from the cycle after start is honoured until done
//  done       out  1   one-cycle pulse when result and response update
//  result     out  12  last complete conversion
//  response   out  8   result[11:4]; feeds the response PIO in_port
//  pen_down   out  1   synchronised, inverted pen_irq_n
// BEHAVIOUR
//  Reset (async assert, sync release):
//   spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, result=0,
//   response=0, pen_down=0; all synchroniser flops cleared; FSM=IDLE.
//  FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> FINISH -> IDLE.
//   IDLE:     start=1 latches cmd into tx shift reg, clears the rx reg and
//             the bit counter. Next cycle: spi_cs_n=0, busy=1,
//             spi_mosi=cmd[7].
//   CS_SETUP: CLK_DIV cycles with sclk low, then -> SHIFT.
//   SHIFT:    48 half-periods of CLK_DIV cycles each (24 SCLK periods).
//             The half-period counter runs 0..CLK_DIV-1.
//             sclk toggles when the counter wraps.
//             Rising edge k (k=1..24): sample synchronised MISO.
//             Samples for k=9..24 shift into rx[15:0], MSB first.
//             Falling edges 1..7: mosi takes the next cmd bit.
//             Falling edges 8..24: mosi=0.
//             After the 48th half-period: sclk=0 -> CS_HOLD.
//   CS_HOLD:  CLK_DIV cycles, sclk low, cs_n still 0. Then spi_cs_n=1 -> FINISH.
//   FINISH:   one cycle.
//             result<=rx[14:3]  (rx[15] = controller busy bit, discarded).
//             response<=rx[14:7], done=1, busy=0 on the next edge.
//             Then -> IDLE.
//  Timing:    spi_cs_n is low for exactly 50*CLK_DIV cycles.
//             done rises 50*CLK_DIV+2 cycles after the start edge.
//  Back-to-back: start can be honoured in the cycle after done.
//  Atomicity: result and response change only in FINISH, in the same cycle.
//             The PIO never sees a partially shifted byte.
//  start while busy=1: ignored; cmd is not re-captured and no error is flagged.
//  start in the FINISH cycle: ignored.
//  MISO sampling: the sample is the SYNC_STAGES-delayed value, taken at the
//   rising-edge cycle. CLK_DIV >= SYNC_STAGES+1 guarantees MISO is stable a
//   half-period after the slave's falling-edge update.
//  pen_down: updates continuously, independent of the FSM; latency
//   SYNC_STAGES cycles.
//  reset_n asserted mid-transfer: cs_n goes high and sclk low immediately
//   (async). result and response clear to 0. done is not pulsed.
// TESTING (sim with CLK_DIV=4, SYNC_STAGES=2)
//  T1 reset: hold reset_n=0, toggle start/miso.
//     -> cs_n=1, sclk=0, done=0, response=8'h00 throughout.
//  T2 single read: start with cmd=8'h93; slave model returns 16'h52E0.
//     -> mosi bits 10010011; result=12'hA5C; response=8'hA5;
//        done pulse at cycle 202; cs_n low for 200 cycles; 24 sclk rises.
//  T3 busy start: second start with cmd=8'hD3 at cycle 50 of T2.
//     -> ignored; mosi still carries 8'h93; exactly one done pulse.
//  T4 back-to-back: start in the cycle after done, slave returns 16'h7FF8.
//     -> result=12'hFFF, response=8'hFF.
//        response holds 8'hA5 until the FINISH cycle of transfer 2.
//  T5 reset mid-op: reset_n=0 at rising sclk #12, released 5 cycles later.
//     -> cs_n=1 same cycle, result=0, no done.
//        A new start then completes normally.
//  T6 pen: pen_irq_n 1->0->1, pulses of 10 cycles, during idle and during
//     a transfer.
//     -> pen_down follows, inverted, with 2-cycle lag; transfer unaffected.

Source files
------------

// File: rtl/lt24_touch_response_if.sv
// SPI + pen-interrupt pins between the LT24 touch controller and its master.
//   spi_sclk  : SPI clock, driven by the master, idles low
//   spi_cs_n  : chip select, active-low, driven by the master
//   spi_mosi  : master data out / controller DIN
//   spi_miso  : controller DOUT / master data in
//   pen_irq_n : controller PENIRQ, active-low, asynchronous to clk
interface lt24_touch_response_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic pen_irq_n;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  pen_irq_n
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output pen_irq_n
  );
endinterface

// File: rtl/lt24_touch_response.sv
// SPI master for the LT24 (ADS7843-compatible) touch controller.
// A start pulse shifts out an 8-bit command and reads back a 12-bit
// conversion; the upper 8 bits are published as a stable response byte
// for the downstream 8-bit response PIO.
//   clk, reset_n : system clock, async active-low reset
//   start, cmd   : one-cycle request and its command byte (IDLE only)
//   spi          : SPI pins and PENIRQ (master modport)
//   busy, done   : transfer in progress / one-cycle completion pulse
//   result       : last complete 12-bit conversion
//   response     : result[11:4], feeds the response PIO in_port
//   pen_down     : synchronised, inverted PENIRQ
module lt24_touch_response #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [7:0]                   cmd,
  lt24_touch_response_if.master        spi,
  output logic                         busy,
  output logic                         done,
  output logic [11:0]                  result,
  output logic [7:0]                   response,
  output logic                         pen_down
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALVES = 48;
  localparam int unsigned HALF_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [HALF_W-1:0]      half_q, half_d;
  logic [6:0]             tx_q, tx_d;
  logic [14:0]            rx_q, rx_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_d, done_d;
  logic [11:0]            result_d;
  logic [7:0]             response_d;
  logic [SYNC_STAGES-1:0] miso_sync;
  logic [SYNC_STAGES-1:0] pen_sync;
  logic                   miso_s_c;
  logic                   div_wrap_c;

  assign spi.spi_sclk = sclk_q;
  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_mosi = mosi_q;

  assign miso_s_c   = miso_sync[SYNC_STAGES-1];
  assign pen_down   = pen_sync[SYNC_STAGES-1];
  assign div_wrap_c = (div_q == DIV_W'(CLK_DIV - 1));

  // Input synchronisers; the pen chain stores the inverted level so a
  // cleared chain means "pen up".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_sync <= '0;
      pen_sync  <= '0;
    end else begin
      miso_sync <= {miso_sync[SYNC_STAGES-2:0], spi.spi_miso};
      pen_sync  <= {pen_sync[SYNC_STAGES-2:0], ~spi.pen_irq_n};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-register-value logic
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy;
    done_d     = 1'b0;
    result_d   = result;
    response_d = response;

    case (state_q)
      IDLE: begin
        if (start) begin
          // cmd[7] goes straight to MOSI; the remaining 7 bits follow on falling edges
          tx_d    = cmd[6:0];
          mosi_d  = cmd[7];
          rx_d    = '0;
          div_d   = '0;
          half_d  = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (div_wrap_c) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (div_wrap_c) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: 24 samples shift through; the controller busy bit
            // and command-phase samples fall off the top.
            rx_d = {rx_q[13:0], miso_s_c};
          end else begin
            // Falling edge: zeros shift in behind the command bits
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end
          if (half_q == HALF_W'(HALVES - 1)) begin
            half_d  = '0;
            state_d = CS_HOLD;
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      CS_HOLD: begin
        if (div_wrap_c) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          state_d = FINISH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      FINISH: begin
        // result and response update together so the PIO never sees a partial byte
        result_d   = rx_q[14:3];
        response_d = rx_q[14:7];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      half_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      response <= '0;
    end else begin
      div_q    <= div_d;
      half_q   <= half_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
      response <= response_d;
    end
  end

endmodule

// File: tb/tb_lt24_touch_response.sv
// Self-checking bench for lt24_touch_response (CLK_DIV=4, SYNC_STAGES=2).
module tb_lt24_touch_response;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  cmd;
  logic        busy;
  logic        done;
  logic [11:0] result;
  logic [7:0]  response;
  logic        pen_down;

  lt24_touch_response_if bus();

  lt24_touch_response #(.CLK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .cmd      (cmd),
    .spi      (bus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .response (response),
    .pen_down (pen_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] word;
    logic [11:0] exp_result;
    logic [7:0]  exp_resp;
    bit          busy_start;
  } vec_t;

  vec_t vecs[5];

  // Slave model and bus monitor state
  logic [15:0] slave_word = 16'h0;
  logic        slave_miso = 1'b0;
  logic        miso_tgl   = 1'b0;
  logic        sclk_prev  = 1'b0;
  logic        cs_prev    = 1'b1;
  int          rise_cnt   = 0;
  int          fall_cnt   = 0;
  int          cs_low     = 0;
  int          done_cnt   = 0;
  logic [7:0]  mosi_cap   = 8'h0;
  logic        mosi_tail  = 1'b0;
  int          n_xfers    = 0;

  assign bus.spi_miso = slave_miso ^ miso_tgl;

  // ADS7843-style slave: DOUT changes after SCLK falls; word bit 15 appears
  // after falling edge 8 so it is sampled on rising edge 9.
  always @(negedge clk) begin
    if (cs_prev && !bus.spi_cs_n) begin
      rise_cnt   <= 0;
      fall_cnt   <= 0;
      cs_low     <= 1;
      mosi_cap   <= 8'h0;
      mosi_tail  <= 1'b0;
      slave_miso <= 1'b0;
    end else if (!bus.spi_cs_n) begin
      cs_low <= cs_low + 1;
      if (!sclk_prev && bus.spi_sclk) begin
        rise_cnt <= rise_cnt + 1;
        if (rise_cnt < 8) mosi_cap <= {mosi_cap[6:0], bus.spi_mosi};
        else              mosi_tail <= mosi_tail | bus.spi_mosi;
      end
      if (sclk_prev && !bus.spi_sclk) begin
        fall_cnt <= fall_cnt + 1;
        if (fall_cnt >= 7 && fall_cnt <= 22)
          slave_miso <= slave_word[4'(22 - fall_cnt)];
      end
    end
    if (done) done_cnt <= done_cnt + 1;
    sclk_prev <= bus.spi_sclk;
    cs_prev   <= bus.spi_cs_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is honoured on the following posedge.
  task automatic run_transfer(input vec_t v, input logic [7:0] prev_resp,
                              input logic [11:0] prev_result);
    bit seen = 0;
    bit held = 1;
    int done_at = 0;
    slave_word = v.word;
    cmd        = v.cmd;
    start      = 1'b1;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
      end
      if (v.busy_start && cyc == 50) begin
        start = 1'b1;
        cmd   = 8'hD3;
      end
      if (v.busy_start && cyc == 51) start = 1'b0;
      if (done) begin
        seen    = 1;
        done_at = cyc;
      end else if (response !== prev_resp || result !== prev_result) begin
        held = 0;
      end
    end
    n_xfers++;
    check("done_seen", 32'(seen), 32'd1);
    check("done_cycle", 32'(done_at), 32'd202);
    check("cs_low_cycles", 32'(cs_low), 32'd200);
    check("sclk_rises", 32'(rise_cnt), 32'd24);
    check("mosi_cmd", 32'(mosi_cap), 32'(v.cmd));
    check("mosi_tail_zero", 32'(mosi_tail), 32'd0);
    check("result", 32'(result), 32'(v.exp_result));
    check("response", 32'(response), 32'(v.exp_resp));
    check("busy_fall", 32'(busy), 32'd0);
    check("outputs_held", 32'(held), 32'd1);
  endtask

  // Called at a negedge; pen_irq_n low for 10 cycles, 2-cycle lag expected.
  task automatic pen_pulse(input string tag);
    bus.pen_irq_n = 1'b0;
    @(negedge clk);
    check({tag, "_down_lag1"}, 32'(pen_down), 32'd0);
    @(negedge clk);
    check({tag, "_down_lag2"}, 32'(pen_down), 32'd1);
    repeat (8) @(negedge clk);
    bus.pen_irq_n = 1'b1;
    @(negedge clk);
    check({tag, "_up_lag1"}, 32'(pen_down), 32'd1);
    @(negedge clk);
    check({tag, "_up_lag2"}, 32'(pen_down), 32'd0);
  endtask

  initial begin
    logic [7:0]  prev_resp;
    logic [11:0] prev_result;
    int          rises;
    logic        p;
    bit          hit;
    int          dcnt;

    vecs[0] = '{cmd: 8'h93, word: 16'h52E0, exp_result: 12'hA5C, exp_resp: 8'hA5, busy_start: 1'b1};
    vecs[1] = '{cmd: 8'hD3, word: 16'h7FF8, exp_result: 12'hFFF, exp_resp: 8'hFF, busy_start: 1'b0};
    vecs[2] = '{cmd: 8'h90, word: 16'h0000, exp_result: 12'h000, exp_resp: 8'h00, busy_start: 1'b0};
    vecs[3] = '{cmd: 8'hC5, word: 16'h1234, exp_result: 12'h246, exp_resp: 8'h24, busy_start: 1'b0};
    vecs[4] = '{cmd: 8'hB1, word: 16'hFFFF, exp_result: 12'hFFF, exp_resp: 8'hFF, busy_start: 1'b0};

    // Reset held while inputs toggle
    reset_n       = 1'b0;
    start         = 1'b0;
    cmd           = 8'h93;
    bus.pen_irq_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start    = ~start;
      miso_tgl = ~miso_tgl;
      check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
      check("rst_sclk", 32'(bus.spi_sclk), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_response", 32'(response), 32'd0);
    end
    check("rst_pen_down", 32'(pen_down), 32'd0);
    start    = 1'b0;
    miso_tgl = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_mosi", 32'(bus.spi_mosi), 32'd0);

    pen_pulse("pen_idle");
    @(negedge clk);

    // Back-to-back table: each start lands in the cycle after the previous done
    prev_resp   = 8'h00;
    prev_result = 12'h000;
    for (int i = 0; i < 5; i++) begin
      run_transfer(vecs[i], prev_resp, prev_result);
      prev_resp   = vecs[i].exp_resp;
      prev_result = vecs[i].exp_result;
    end

    // Reset at rising SCLK #12 of a transfer
    cmd        = 8'h93;
    slave_word = 16'h52E0;
    start      = 1'b1;
    rises      = 0;
    p          = 1'b0;
    hit        = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!p && bus.spi_sclk) rises++;
      p = bus.spi_sclk;
      if (rises == 12) hit = 1;
    end
    check("midop_reached", 32'(hit), 32'd1);
    dcnt    = done_cnt;
    reset_n = 1'b0;
    #1;
    check("midop_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("midop_sclk", 32'(bus.spi_sclk), 32'd0);
    check("midop_result", 32'(result), 32'd0);
    check("midop_response", 32'(response), 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midop_no_done", 32'(done_cnt), 32'(dcnt));

    // Fresh transfer after reset, with a pen pulse during it
    fork
      run_transfer(vecs[1], 8'h00, 12'h000);
      begin
        repeat (60) @(negedge clk);
        pen_pulse("pen_xfer");
      end
    join
    repeat (3) @(negedge clk);
    check("done_pulse_count", 32'(done_cnt), 32'(n_xfers));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
